// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - fetch stage memory, redirect and decoder handshake bundle
interface fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] iword;
    logic [31:0] pc;
    logic        iword_valid;
    logic        iword_ready;

    modport master (
        output imem_req, imem_addr, iword, pc, iword_valid,
        input  imem_rvalid, imem_rdata, redirect_valid, redirect_pc, iword_ready
    );

    modport slave (
        input  imem_req, imem_addr, iword, pc, iword_valid,
        output imem_rvalid, imem_rdata, redirect_valid, redirect_pc, iword_ready
    );
endinterface

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch with one request in flight and a pc/word FIFO
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic          clk,
    input  logic          rst,
    fetch_unit_if.master  bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {IDLE, WAIT, DISCARD} state_t;

    state_t        state_q, state_d;
    logic [31:0]   fetch_pc_q;
    logic [31:0]   req_pc_q;
    logic [31:0]   pc_mem   [DEPTH];
    logic [31:0]   word_mem [DEPTH];
    logic [PW-1:0] rd_ptr, wr_ptr;
    logic [CW-1:0] count;
    logic [CW:0]   count_after;
    logic          push, pop, issue, can_state;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign pop  = (count != '0) && bus.iword_ready;
    assign push = (state_q == WAIT) && bus.imem_rvalid;

    assign bus.iword       = word_mem[rd_ptr];
    assign bus.pc          = pc_mem[rd_ptr];
    assign bus.iword_valid = (count != '0);
    assign bus.imem_req    = issue;
    assign bus.imem_addr   = fetch_pc_q;

    // Issue decision: a free state slot, room after this cycle's push/pop, no redirect
    always_comb begin
        count_after = {1'b0, count} + (CW+1)'(push) - (CW+1)'(pop);
        can_state   = (state_q == IDLE) || ((state_q == WAIT) && bus.imem_rvalid);
        issue       = !rst && !bus.redirect_valid && can_state &&
                      (count_after < (CW+1)'(DEPTH));
    end

    // Next-state logic; a redirect turns an outstanding kept response into a dropped one
    always_comb begin
        state_d = state_q;
        if (bus.redirect_valid) begin
            case (state_q)
                WAIT:    state_d = bus.imem_rvalid ? IDLE : DISCARD;
                DISCARD: state_d = bus.imem_rvalid ? IDLE : DISCARD;
                default: state_d = IDLE;
            endcase
        end else begin
            case (state_q)
                IDLE:    state_d = issue ? WAIT : IDLE;
                WAIT:    state_d = bus.imem_rvalid ? (issue ? WAIT : IDLE) : WAIT;
                DISCARD: state_d = bus.imem_rvalid ? IDLE : DISCARD;
                default: state_d = IDLE;
            endcase
        end
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Fetch address and the address of the request in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc_q <= {RESET_PC[31:2], 2'b00};
            req_pc_q   <= {RESET_PC[31:2], 2'b00};
        end else if (bus.redirect_valid) begin
            fetch_pc_q <= {bus.redirect_pc[31:2], 2'b00};
        end else if (issue) begin
            req_pc_q   <= fetch_pc_q;
            fetch_pc_q <= fetch_pc_q + 32'd4;
        end
    end

    // FIFO storage and pointers; storage is cleared so the head never reads X
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                pc_mem[i]   <= '0;
                word_mem[i] <= '0;
            end
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (bus.redirect_valid) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                pc_mem[wr_ptr]   <= req_pc_q;
                word_mem[wr_ptr] <= bus.imem_rdata;
                wr_ptr           <= ptr_inc(wr_ptr);
            end
            if (pop) rd_ptr <= ptr_inc(rd_ptr);
            count <= count_after[CW-1:0];
        end
    end
endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage, directly upstream of the decoder. It holds the fetch PC, issues word reads to instruction memory with at most one request in flight, and buffers returned words with their PCs in a small FIFO. It presents `iword`/`pc` to the decoder under a valid/ready handshake and accepts PC redirects from the branch/jump resolution logic.

## Interface
- `RESET_PC`, default 32'h0000_0000: fetch address after reset.
- `DEPTH`, default 2: FIFO entries. Legal range is 2..8.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `imem_req`  out  1  read request, valid for one cycle per request.
- `imem_addr`  out  32  word address of the request; bits [1:0] are always 0.
- `imem_rvalid`  in  1  response strobe, arriving 1 or more cycles after the request.
- `imem_rdata`  in  32  response word, qualified by `imem_rvalid`.
- `redirect_valid`  in  1  one-cycle PC redirect strobe.
- `redirect_pc`  in  32  redirect target; bits [1:0] are ignored and treated as 0.
- `iword`  out  32  instruction word to the decoder (FIFO head).
- `pc`  out  32  PC of `iword`.
- `iword_valid`  out  1  FIFO not empty.
- `iword_ready`  in  1  decoder accepts the head entry.

## Operation
- Registers:
  - `fetch_pc`: next address to request.
  - FIFO of `{pc, iword}` entries with a count 0..DEPTH.
  - `state`: one of IDLE, WAIT, DISCARD.
- States:
  - IDLE: no request in flight.
  - WAIT: one request in flight; its response will be kept.
  - DISCARD: one request in flight; its response will be dropped.
- Pop: `iword_valid && iword_ready`.
- Push: `imem_rvalid` in WAIT. The pushed entry is `{req_pc, imem_rdata}`, where `req_pc` is the address latched at issue.
- `imem_req` is asserted when all of the following hold:
  - state is IDLE, or state is WAIT with `imem_rvalid` high (back-to-back issue);
  - count after this cycle's push/pop, plus the new request, is at most DEPTH (no overflow is possible);
  - `redirect_valid` is low;
  - `rst` is low.
- On issue: `imem_addr = fetch_pc`, latch `req_pc`, `fetch_pc <= fetch_pc + 4` (mod 2^32, wraps 0xFFFF_FFFC to 0), next state WAIT.
- WAIT with `imem_rvalid` and no new issue goes to IDLE.
- DISCARD with `imem_rvalid`: drop the response, go to IDLE. Never issue in that same cycle.
- Redirect has priority over every other event in its cycle:
  - FIFO flushed: count becomes 0; a same-cycle pop or push is void.
  - `fetch_pc <= {redirect_pc[31:2], 2'b00}`.
  - No issue that cycle.
  - Next state:
    - WAIT with no `imem_rvalid` goes to DISCARD.
    - WAIT with `imem_rvalid` goes to IDLE (response dropped).
    - DISCARD stays DISCARD unless `imem_rvalid` is high, then IDLE.
    - IDLE stays IDLE.
- Simultaneous push and pop: count unchanged, order preserved.
- Pop of the head while the FIFO is full frees space that the same-cycle issue condition may use.
- `iword_valid = (count != 0)`. `iword`/`pc` are undefined when `iword_valid` is low but must not be X after reset.

## Timing
- Reset (asynchronous assert, synchronous release):
  - state IDLE, `fetch_pc = RESET_PC`, count 0.
  - FIFO storage 0, so `iword = 0` and `pc = 0`.
  - `iword_valid = 0`.
  - `imem_req = 0` while `rst` is high.
- First cycle after release: `imem_req = 1`, `imem_addr = RESET_PC`.
- With 1-cycle memory latency and `iword_ready` held high:
  - one request per cycle, addresses RESET_PC, +4, +8, ...;
  - `iword_valid` rises 2 cycles after the first request;
  - then one instruction per cycle.
- Request to FIFO output: response cycle + 1. `iword` is registered; there is no combinational path from `imem_rdata`.
- `iword_valid`/`iword`/`pc` hold stable while `iword_valid && !iword_ready`.
- Redirect in cycle N:
  - `iword_valid = 0` in N+1;
  - earliest `imem_req` with `redirect_pc` is in N+1 (from IDLE or WAIT+rvalid), otherwise the cycle after the discarded response.
- Reset mid-operation: in-flight response is ignored (state IDLE, FIFO empty). Memory must tolerate an abandoned request.

## Test plan
- Reset, `RESET_PC` = 0x100, latency 1, ready high → requests 0x100, 0x104, 0x108 on consecutive cycles; decoder sees pc 0x100/0x104/0x108 with the matching rdata, one per cycle after 2-cycle fill.
- `iword_ready` low for 5 cycles → count saturates at DEPTH, `imem_req` stays 0, head pc/iword stable; on ready high, entries drain in order and fetch resumes with no lost or duplicated PC.
- Latency 3, redirect to 0x2002 while WAIT → state DISCARD, stale rdata not pushed, next request address 0x2000, first delivered pc 0x2000.
- Redirect in the same cycle as `imem_rvalid` with the FIFO holding 2 entries → FIFO empty next cycle, response dropped, `imem_req` with 0x2000 next cycle.
- `fetch_pc` = 0xFFFF_FFFC → next request 0x0000_0000.
- Assert `rst` asynchronously between clock edges during WAIT with a full FIFO → outputs reach reset values immediately, a late `imem_rvalid` is ignored, fetch restarts at `RESET_PC`.
